// File: rtl/audio_pkg.sv
// Shared definitions for the audio clip playback path: FSM encoding,
// default widths, default sample divider and the default clip table.
package audio_pkg;

   localparam int DEF_ADDR_WIDTH = 19;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_NUM_CLIPS  = 4;
   localparam int DEF_SAMPLE_DIV = 2268;

   // Clip 0 occupies the LSBs; end addresses are inclusive.
   localparam logic [DEF_NUM_CLIPS*DEF_ADDR_WIDTH-1:0] DEF_CLIP_START =
      {19'd460000, 19'd396900, 19'd264600, 19'd0};
   localparam logic [DEF_NUM_CLIPS*DEF_ADDR_WIDTH-1:0] DEF_CLIP_END =
      {19'd524287, 19'd459999, 19'd396899, 19'd264599};

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_PRESENT = 3'd3,
      ST_PACE    = 3'd4
   } seq_state_t;

endpackage

// File: rtl/audio_clip_sequencer_if.sv
// ROM read port and sample stream towards the PWM modulator.
// Sample stream: a sample transfers on a rising edge where Sample_valid and
// Sample_ready are both 1; while Sample_valid is 1 and no transfer has
// happened, Sample_data is held stable and Sample_valid stays asserted
// (unless playback is aborted). Rom_data is valid one cycle after Rom_en.
interface audio_clip_sequencer_if
   import audio_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   logic                  Rom_en;
   logic [ADDR_WIDTH-1:0] Rom_addr;
   logic [DATA_WIDTH-1:0] Rom_data;
   logic [DATA_WIDTH-1:0] Sample_data;
   logic                  Sample_valid;
   logic                  Sample_ready;

   modport master (
      output Rom_en, Rom_addr, Sample_data, Sample_valid,
      input  Rom_data, Sample_ready
   );

   modport slave (
      input  Rom_en, Rom_addr, Sample_data, Sample_valid,
      output Rom_data, Sample_ready
   );
endinterface

// File: rtl/sample_rate_ticker.sv
// Free-running divider that pulses once every DIV enabled cycles.
module sample_rate_ticker
   import audio_pkg::*;
#(
   parameter int DIV = DEF_SAMPLE_DIV
)(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clear,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q;

   // Count 0..DIV-1 while enabled; clear forces the count back to 0.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + 1'b1;
      end
   end

   assign tick = en && (cnt_q == CW'(DIV - 1));
endmodule

// File: rtl/audio_clip_sequencer.sv
// Playback controller: picks a clip by fixed priority, walks its ROM
// addresses at the sample rate and hands each sample to the modulator.
module audio_clip_sequencer
   import audio_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_CLIPS  = DEF_NUM_CLIPS,
   parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
   parameter logic [NUM_CLIPS*ADDR_WIDTH-1:0] CLIP_START = DEF_CLIP_START,
   parameter logic [NUM_CLIPS*ADDR_WIDTH-1:0] CLIP_END   = DEF_CLIP_END,
   localparam int CLIP_W = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1
)(
   input  logic                 Clock_100MHz,
   input  logic                 Clear_n,
   input  logic [NUM_CLIPS-1:0] Play_req,
   input  logic                 Stop,
   input  logic                 Loop_en,
   audio_clip_sequencer_if.master bus,
   output logic                 Busy,
   output logic [CLIP_W-1:0]    Active_clip,
   output logic                 Done,
   output logic                 Underrun,
   output logic                 AUD_SD,
   output seq_state_t           dbg_state
);

   seq_state_t            state_q, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
   logic [CLIP_W-1:0]     clip_q, clip_nxt;
   logic                  done_q, done_nxt;
   logic                  underrun_q, underrun_nxt;
   logic [DATA_WIDTH-1:0] sample_q;

   logic [CLIP_W-1:0]     req_idx;
   logic [ADDR_WIDTH-1:0] req_start, req_end, cur_start, cur_end;
   logic                  busy, tick, advance;

   assign busy = (state_q != ST_IDLE);

   sample_rate_ticker #(.DIV(SAMPLE_DIV)) u_ticker (
      .clk   (Clock_100MHz),
      .rst_n (Clear_n),
      .en    (busy),
      .clear (!busy),
      .tick  (tick)
   );

   // Fixed priority: the lowest-index asserted request wins.
   always_comb begin
      req_idx = '0;
      for (int i = NUM_CLIPS - 1; i >= 0; i--) begin
         if (Play_req[i]) req_idx = CLIP_W'(i);
      end
   end

   assign req_start = CLIP_START[int'(req_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign req_end   = CLIP_END[int'(req_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign cur_start = CLIP_START[int'(clip_q)*ADDR_WIDTH +: ADDR_WIDTH];
   assign cur_end   = CLIP_END[int'(clip_q)*ADDR_WIDTH +: ADDR_WIDTH];

   // A tick that coincides with the transfer still paces the next fetch,
   // so a late-but-in-time accept does not cost a whole sample period.
   assign advance = tick && ((state_q == ST_PACE) ||
                             (state_q == ST_PRESENT && bus.Sample_ready));

   // Next-state and register-update logic; Stop overrides everything once busy.
   always_comb begin
      state_nxt    = state_q;
      addr_nxt     = addr_q;
      clip_nxt     = clip_q;
      done_nxt     = 1'b0;
      underrun_nxt = underrun_q;
      case (state_q)
         ST_IDLE: begin
            if (!Stop && (|Play_req)) begin
               if (req_end < req_start) begin
                  done_nxt = 1'b1;
               end else begin
                  clip_nxt     = req_idx;
                  addr_nxt     = req_start;
                  underrun_nxt = 1'b0;
                  state_nxt    = ST_FETCH;
               end
            end
         end
         ST_FETCH:   state_nxt = ST_WAIT;
         ST_WAIT:    state_nxt = ST_PRESENT;
         ST_PRESENT: begin
            if (bus.Sample_ready) state_nxt = ST_PACE;
            else if (tick)        underrun_nxt = 1'b1;
         end
         ST_PACE:    state_nxt = ST_PACE;
         default:    state_nxt = ST_IDLE;
      endcase
      if (advance) begin
         // Compare before increment so the address never wraps.
         if (addr_q < cur_end) begin
            addr_nxt  = addr_q + 1'b1;
            state_nxt = ST_FETCH;
         end else if (Loop_en) begin
            addr_nxt  = cur_start;
            state_nxt = ST_FETCH;
         end else begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
         end
      end
      if (Stop && busy) begin
         state_nxt    = ST_IDLE;
         addr_nxt     = addr_q;
         done_nxt     = 1'b0;
         underrun_nxt = underrun_q;
      end
   end

   // FSM state and playback registers.
   always_ff @(posedge Clock_100MHz) begin
      if (!Clear_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         clip_q     <= '0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         addr_q     <= addr_nxt;
         clip_q     <= clip_nxt;
         done_q     <= done_nxt;
         underrun_q <= underrun_nxt;
      end
   end

   // Capture the ROM word in WAIT, the cycle after the read was issued.
   always_ff @(posedge Clock_100MHz) begin
      if (!Clear_n) begin
         sample_q <= '0;
      end else if (state_q == ST_WAIT) begin
         sample_q <= bus.Rom_data;
      end
   end

   assign bus.Rom_en       = (state_q == ST_FETCH);
   assign bus.Rom_addr     = addr_q;
   assign bus.Sample_data  = sample_q;
   assign bus.Sample_valid = (state_q == ST_PRESENT);
   assign Busy             = busy;
   assign AUD_SD           = busy;
   assign Active_clip      = clip_q;
   assign Done             = done_q;
   assign Underrun         = underrun_q;
   assign dbg_state        = state_q;

endmodule
